// File: rtl/neuron_readout_ctrl.sv
// Periodic readout sequencer for the neuron array: pulses rd, captures
// the read-phase words into a FWFT FIFO and streams them out.
module neuron_readout_ctrl #(
  parameter int FP_DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH     = 32,
  parameter int FIFO_AW        = 5,
  parameter int INTERVAL_WIDTH = 16,
  parameter int MAX_WORDS      = 17
) (
  input  logic                      clk,
  input  logic                      reset_l,
  input  logic                      enable,
  input  logic [INTERVAL_WIDTH-1:0] interval,
  output logic                      rd,
  input  logic [FP_DATA_WIDTH-1:0]  outs,
  input  logic                      readDone,
  output logic [FP_DATA_WIDTH-1:0]  m_data,
  output logic                      m_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [15:0]               sample_cnt,
  output logic                      overflow,
  output logic                      busy
);

  localparam int WCW = $clog2(MAX_WORDS + 1);
  localparam int PW  = FIFO_AW + 1;

  localparam logic [WCW-1:0] WMAX = WCW'(MAX_WORDS);
  localparam logic [PW-1:0]  DEPTH_P = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0]  NEED = PW'(MAX_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_CAPT
  } state_t;

  state_t state, state_nx;

  logic [INTERVAL_WIDTH-1:0] wait_cnt, wait_nx;
  logic [INTERVAL_WIDTH-1:0] interval_ld;
  logic [WCW-1:0] word_cnt, word_nx;

  logic push, push_ok, pop;
  logic ovf_set, done;
  logic full, empty, space_ok;
  logic [PW-1:0] wptr, rptr, used, free;

  logic [FP_DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [FP_DATA_WIDTH:0] head;

  assign interval_ld = (interval == '0)
                     ? INTERVAL_WIDTH'(1)
                     : interval;

  assign empty = (wptr == rptr);
  assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                 (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign used  = wptr - rptr;
  assign free  = DEPTH_P - used;
  assign space_ok = (free >= NEED);

  assign pop     = !empty && m_ready;
  assign push_ok = push && !full;

  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    word_nx  = word_cnt;
    push     = 1'b0;
    ovf_set  = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable) begin
          wait_nx  = interval_ld;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt != '0)
          wait_nx = wait_cnt - INTERVAL_WIDTH'(1);
        else if (!enable)
          state_nx = S_IDLE;
        else if (space_ok)
          state_nx = S_REQ;
      end
      S_REQ: begin
        word_nx  = '0;
        state_nx = S_CAPT;
      end
      S_CAPT: begin
        // A runaway readout keeps draining the array but stops filling.
        if (word_cnt == WMAX) begin
          ovf_set = 1'b1;
        end else begin
          push    = 1'b1;
          word_nx = word_cnt + WCW'(1);
        end
        if (readDone) begin
          done     = 1'b1;
          wait_nx  = interval_ld;
          state_nx = S_WAIT;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      word_cnt   <= '0;
      rd         <= 1'b0;
      sample_cnt <= '0;
      overflow   <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      word_cnt <= word_nx;
      rd       <= (state_nx == S_REQ);
      if (done)
        sample_cnt <= sample_cnt + 16'd1;
      if (ovf_set || (push && full))
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok)
        wptr <= wptr + PW'(1);
      if (pop)
        rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wptr[FIFO_AW-1:0]] <= {readDone, outs};
  end

  assign head    = mem[rptr[FIFO_AW-1:0]];
  assign m_valid = !empty;
  assign m_data  = empty ? '0 : head[FP_DATA_WIDTH-1:0];
  assign m_last  = !empty && head[FP_DATA_WIDTH];
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_neuron_readout_ctrl.sv
// Directed bench for neuron_readout_ctrl: array model drives words,
// a scoreboard queue checks the output stream.
module tb_neuron_readout_ctrl;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        enable;
  logic [15:0] interval;
  logic        rd;
  logic [15:0] outs;
  logic        readDone;
  logic [15:0] m_data;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] sample_cnt;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cycles = 0;
  int popped = 0;

  logic [16:0] exp_q[$];
  logic [15:0] words[32];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (rd) rd_cycles++;
  end

  neuron_readout_ctrl dut (
    .clk(clk),
    .reset_l(reset_l),
    .enable(enable),
    .interval(interval),
    .rd(rd),
    .outs(outs),
    .readDone(readDone),
    .m_data(m_data),
    .m_last(m_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .sample_cnt(sample_cnt),
    .overflow(overflow),
    .busy(busy)
  );

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [16:0] e;
    if (reset_l && m_valid && m_ready) begin
      popped++;
      e = 17'bx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("stream_word", {15'd0, m_last, m_data}, {15'd0, e});
    end
  end

  task automatic fill(input logic [15:0] seed);
    for (int i = 0; i < 32; i++)
      words[i] = seed ^ 16'(i * 16'h1357);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_l  = 1'b0;
    enable   = 1'b0;
    outs     = '0;
    readDone = 1'b0;
    m_ready  = 1'b0;
    interval = '0;
    #1;
    exp_q.delete();
    check("rst_rd", rd, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_data", m_data, 0);
    check("rst_cnt", sample_cnt, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
  endtask

  // Returns how many edges passed until rd was seen high.
  task automatic wait_rd(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!rd && n < 200);
    check("rd_seen", rd, 1);
  endtask

  task automatic serve(input int n, input int done_at,
                       input bit drop_en);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (i == 0 && drop_en) enable = 1'b0;
      outs     = words[i];
      readDone = (i == done_at);
      if (i < 17) exp_q.push_back({readDone, words[i]});
    end
    @(posedge clk);
    #1;
    outs     = '0;
    readDone = 1'b0;
  endtask

  initial begin : stim
    int n, t1, t2, base, pbase;
    logic [15:0] head0;
    reset_l  = 1'b0;
    enable   = 1'b0;
    interval = '0;
    outs     = '0;
    readDone = 1'b0;
    m_ready  = 1'b0;

    // single two-word sample
    do_reset();
    interval = 16'd4;
    m_ready  = 1'b1;
    base     = rd_cycles;
    @(posedge clk);
    #1 enable = 1'b1;
    wait_rd(n);
    // enable is taken on the first edge, then interval+1 WAIT cycles
    check("t1_rd_delay", n, 6);
    enable   = 1'b0;
    words[0] = 16'hA5A5;
    words[1] = 16'h0F0F;
    serve(2, 1, 1'b0);
    repeat (20) @(negedge clk);
    check("t1_drained", exp_q.size(), 0);
    check("t1_samples", sample_cnt, 1);
    check("t1_rd_once", rd_cycles - base, 1);
    check("t1_busy", busy, 0);
    check("t1_ovf", overflow, 0);

    // back-to-back samples with interval 0
    do_reset();
    interval = 16'd0;
    m_ready  = 1'b1;
    base     = rd_cycles;
    @(posedge clk);
    #1 enable = 1'b1;
    wait_rd(n);
    t1 = cyc;
    fill(16'h1111);
    serve(2, 1, 1'b0);
    wait_rd(n);
    t2 = cyc;
    enable = 1'b0;
    fill(16'h2222);
    serve(2, 1, 1'b0);
    repeat (20) @(negedge clk);
    check("t2_gap", (t2 - t1 - 1) >= 2, 1);
    check("t2_samples", sample_cnt, 2);
    check("t2_drained", exp_q.size(), 0);
    check("t2_rd_twice", rd_cycles - base, 2);

    // backpressure: full 17-word sample with the sink stalled
    do_reset();
    interval = 16'd2;
    m_ready  = 1'b0;
    base     = rd_cycles;
    pbase    = popped;
    @(posedge clk);
    #1 enable = 1'b1;
    wait_rd(n);
    fill(16'h3C00);
    head0 = words[0];
    serve(17, 16, 1'b0);
    repeat (30) @(negedge clk);
    check("t3_stall_rd", rd_cycles - base, 1);
    check("t3_busy", busy, 1);
    check("t3_valid", m_valid, 1);
    check("t3_head", m_data, head0);
    check("t3_head_last", m_last, 0);
    @(posedge clk);
    #1 m_ready = 1'b1;
    wait_rd(n);
    enable = 1'b0;
    fill(16'h5A00);
    serve(3, 2, 1'b0);
    repeat (40) @(negedge clk);
    check("t3_samples", sample_cnt, 2);
    check("t3_popped", popped - pbase, 20);
    check("t3_drained", exp_q.size(), 0);

    // runaway readout: readDone only on the 21st word
    do_reset();
    interval = 16'd1;
    m_ready  = 1'b1;
    pbase    = popped;
    @(posedge clk);
    #1 enable = 1'b1;
    wait_rd(n);
    enable = 1'b0;
    fill(16'h7700);
    serve(21, 20, 1'b0);
    repeat (5) @(negedge clk);
    check("t4_ovf", overflow, 1);
    check("t4_samples", sample_cnt, 1);
    repeat (20) @(negedge clk);
    check("t4_ovf_sticky", overflow, 1);
    check("t4_popped", popped - pbase, 17);
    check("t4_drained", exp_q.size(), 0);

    // enable drops in the cycle after rd
    do_reset();
    interval = 16'd3;
    m_ready  = 1'b1;
    base     = rd_cycles;
    @(posedge clk);
    #1 enable = 1'b1;
    wait_rd(n);
    fill(16'h9900);
    serve(3, 2, 1'b1);
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_busy_fall", n, 4);
    repeat (20) @(negedge clk);
    check("t5_rd_once", rd_cycles - base, 1);
    check("t5_samples", sample_cnt, 1);
    check("t5_drained", exp_q.size(), 0);

    // asynchronous reset during REQ and during capture
    do_reset();
    interval = 16'd1;
    m_ready  = 1'b0;
    @(posedge clk);
    #1 enable = 1'b1;
    wait_rd(n);
    #1 reset_l = 1'b0;
    #1;
    check("t6_req_rd", rd, 0);
    check("t6_req_busy", busy, 0);
    @(negedge clk);
    reset_l = 1'b1;
    wait_rd(n);
    fill(16'hC300);
    serve(2, -1, 1'b0);
    #2;
    check("t6_pre_valid", m_valid, 1);
    check("t6_pre_busy", busy, 1);
    reset_l = 1'b0;
    #1;
    check("t6_rd", rd, 0);
    check("t6_valid", m_valid, 0);
    check("t6_busy", busy, 0);
    exp_q.delete();
    enable = 1'b0;
    @(negedge clk);
    reset_l = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_empty", m_valid, 0);
    check("t6_samples", sample_cnt, 0);
    check("t6_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
